// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: steers each valid slot word of a framed serial stream
// to its per-channel output register, tracking slot position and flagging framing errors.
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [N_CH*W-1:0] ch_data,
    output logic [N_CH-1:0]   ch_valid,
    output logic              frame_done,
    output logic              sync_err
);

    localparam int SLOT_W = $clog2(N_CH);

    localparam logic STATE_HUNT = 1'b0;
    localparam logic STATE_LOCK = 1'b1;

    localparam logic [SLOT_W-1:0] SLOT_FIRST = '0;
    localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(N_CH - 1);

    logic              state_reg, state_next;
    logic [SLOT_W-1:0] slot_reg, slot_next;
    logic [W-1:0]      ch_reg [N_CH];
    logic [N_CH-1:0]   ch_valid_reg;
    logic              frame_done_reg, frame_done_next;
    logic              sync_err_reg, sync_err_next;

    logic              wr_en;
    logic [SLOT_W-1:0] wr_slot;
    logic [N_CH-1:0]   wr_hit;

    always_comb begin
        state_next      = state_reg;
        slot_next       = slot_reg;
        frame_done_next = 1'b0;
        sync_err_next   = 1'b0;
        wr_en           = 1'b0;
        wr_slot         = slot_reg;

        if (din_valid) begin
            if (state_reg == STATE_HUNT) begin
                // Words without sync are silently discarded until alignment is found.
                if (frame_sync) begin
                    wr_en      = 1'b1;
                    wr_slot    = SLOT_FIRST;
                    slot_next  = SLOT_ONE;
                    state_next = STATE_LOCK;
                end
            end else begin
                if (frame_sync) begin
                    // Sync always re-aligns to slot 0; arriving early is an error.
                    sync_err_next = (slot_reg != SLOT_FIRST);
                    wr_en         = 1'b1;
                    wr_slot       = SLOT_FIRST;
                    slot_next     = SLOT_ONE;
                end else if (slot_reg == SLOT_FIRST) begin
                    sync_err_next = 1'b1;
                    slot_next     = SLOT_FIRST;
                    state_next    = STATE_HUNT;
                end else begin
                    wr_en   = 1'b1;
                    wr_slot = slot_reg;
                    if (slot_reg == SLOT_LAST) begin
                        frame_done_next = 1'b1;
                        slot_next       = SLOT_FIRST;
                    end else begin
                        slot_next = slot_reg + SLOT_ONE;
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign wr_hit[gi]             = wr_en && (wr_slot == SLOT_W'(gi));
            assign ch_data[gi*W +: W]     = ch_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= STATE_HUNT;
            slot_reg       <= SLOT_FIRST;
            ch_valid_reg   <= '0;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ch_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            slot_reg       <= slot_next;
            ch_valid_reg   <= wr_hit;
            frame_done_reg <= frame_done_next;
            sync_err_reg   <= sync_err_next;
            for (int i = 0; i < N_CH; i++) begin
                if (wr_hit[i]) begin
                    ch_reg[i] <= din;
                end
            end
        end
    end

    assign ch_valid   = ch_valid_reg;
    assign frame_done = frame_done_reg;
    assign sync_err   = sync_err_reg;

endmodule
